axi4_reg_slice: RTL and testbench



---
 rtl/axi4_reg_slice_if.sv | 88 ++++++++
 rtl/axi4_reg_slice.sv | 174 +++++++++++++++++
 tb/tb_axi4_reg_slice.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi4_reg_slice_if.sv
// -----------------------------------------------------------------------------
// axi4_if : five-channel AXI4 bundle used on both sides of axi4_reg_slice.
//
// Parameters
//   AXI4_ADDRESS_WIDTH  address width of AW/AR
//   AXI4_DATA_WIDTH     data width of W/R (WSTRB is AXI4_DATA_WIDTH/8 bits)
//   AXI4_ID_WIDTH       ID width on AW/AR/B/R
//
// Modports
//   master : drives AW/W/AR payload+valid, bready, rready
//   slave  : drives awready, wready, arready, B/R payload+valid
// -----------------------------------------------------------------------------
interface axi4_if #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 2
);
    // Write address channel
    logic [AXI4_ADDRESS_WIDTH-1:0] awaddr;
    logic [AXI4_ID_WIDTH-1:0]      awid;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awlock;
    logic [3:0]                    awcache;
    logic [2:0]                    awprot;
    logic [3:0]                    awqos;
    logic [3:0]                    awregion;
    logic                          awvalid;
    logic                          awready;
    // Write data channel
    logic [AXI4_DATA_WIDTH-1:0]    wdata;
    logic [AXI4_DATA_WIDTH/8-1:0]  wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;
    // Write response channel
    logic [AXI4_ID_WIDTH-1:0]      bid;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    // Read address channel
    logic [AXI4_ADDRESS_WIDTH-1:0] araddr;
    logic [AXI4_ID_WIDTH-1:0]      arid;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arlock;
    logic [3:0]                    arcache;
    logic [2:0]                    arprot;
    logic [3:0]                    arqos;
    logic [3:0]                    arregion;
    logic                          arvalid;
    logic                          arready;
    // Read data channel
    logic [AXI4_ID_WIDTH-1:0]      rid;
    logic [AXI4_DATA_WIDTH-1:0]    rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_reg_slice.sv
// -----------------------------------------------------------------------------
// axi4_reg_slice : five-channel AXI4 pipeline register slice.
//
// Every channel gets its own independent register buffer so that no valid,
// ready or payload path crosses the slice combinationally. AW, W and AR flow
// s -> m; B and R flow m -> s. Beats are never reordered, merged or altered.
//
// Build option (macro AXI4_REG_SLICE_FULL_TPUT_EN):
//   defined   : 2-entry skid buffer per channel, one beat per cycle sustained
//   undefined : single register per channel, at most one beat per two cycles
// Latency through an empty buffer is one cycle in both builds.
//
// Ports
//   clk_i  clock, all state on the rising edge
//   rst_n  asynchronous active-low reset (release must be synchronous)
//   s      axi4_if.slave  : upstream, faces the master
//   m      axi4_if.master : downstream, faces the memory unit
// -----------------------------------------------------------------------------

// One channel's buffer. in_ready_o and out_valid_o come straight from flops.
module axi4_reg_slice_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic         accept;
    logic         drain;

    assign accept      = in_valid_i && in_ready_o;
    assign drain       = main_valid_q && out_ready_i;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

`ifdef AXI4_REG_SLICE_FULL_TPUT_EN
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;

    // Ready only depends on the skid flag, so a stalled output takes one
    // cycle to show upstream; the skid entry catches the beat in flight.
    assign in_ready_o = !skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            // in_ready_o is low here, so no accept can coincide with this.
            if (drain) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || drain) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    // Single entry: accept only while empty, so accept and drain never overlap.
    assign in_ready_o = !main_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data_i;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end
endmodule

module axi4_reg_slice #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 2
) (
    input  logic   clk_i,
    input  logic   rst_n,
    axi4_if.slave  s,
    axi4_if.master m
);
    localparam int AX_W = AXI4_ADDRESS_WIDTH + AXI4_ID_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4;
    localparam int WD_W = AXI4_DATA_WIDTH + AXI4_DATA_WIDTH/8 + 1;
    localparam int B_W  = AXI4_ID_WIDTH + 2;
    localparam int R_W  = AXI4_ID_WIDTH + AXI4_DATA_WIDTH + 2 + 1;

    logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [WD_W-1:0] w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [R_W-1:0]  r_in, r_out;

    // Forward channels: pack upstream payload, unpack onto downstream.
    assign aw_in = {s.awaddr, s.awid, s.awlen, s.awsize, s.awburst,
                    s.awlock, s.awcache, s.awprot, s.awqos, s.awregion};
    assign {m.awaddr, m.awid, m.awlen, m.awsize, m.awburst,
            m.awlock, m.awcache, m.awprot, m.awqos, m.awregion} = aw_out;
    assign w_in = {s.wdata, s.wstrb, s.wlast};
    assign {m.wdata, m.wstrb, m.wlast} = w_out;
    assign ar_in = {s.araddr, s.arid, s.arlen, s.arsize, s.arburst,
                    s.arlock, s.arcache, s.arprot, s.arqos, s.arregion};
    assign {m.araddr, m.arid, m.arlen, m.arsize, m.arburst,
            m.arlock, m.arcache, m.arprot, m.arqos, m.arregion} = ar_out;

    // Backward channels: pack downstream response, unpack onto upstream.
    assign b_in = {m.bid, m.bresp};
    assign {s.bid, s.bresp} = b_out;
    assign r_in = {m.rid, m.rdata, m.rresp, m.rlast};
    assign {s.rid, s.rdata, s.rresp, s.rlast} = r_out;

    axi4_reg_slice_buf #(.W(AX_W)) u_aw (
        .clk_i(clk_i), .rst_n(rst_n),
        .in_valid_i(s.awvalid), .in_ready_o(s.awready), .in_data_i(aw_in),
        .out_valid_o(m.awvalid), .out_ready_i(m.awready), .out_data_o(aw_out)
    );
    axi4_reg_slice_buf #(.W(WD_W)) u_w (
        .clk_i(clk_i), .rst_n(rst_n),
        .in_valid_i(s.wvalid), .in_ready_o(s.wready), .in_data_i(w_in),
        .out_valid_o(m.wvalid), .out_ready_i(m.wready), .out_data_o(w_out)
    );
    axi4_reg_slice_buf #(.W(AX_W)) u_ar (
        .clk_i(clk_i), .rst_n(rst_n),
        .in_valid_i(s.arvalid), .in_ready_o(s.arready), .in_data_i(ar_in),
        .out_valid_o(m.arvalid), .out_ready_i(m.arready), .out_data_o(ar_out)
    );
    axi4_reg_slice_buf #(.W(B_W)) u_b (
        .clk_i(clk_i), .rst_n(rst_n),
        .in_valid_i(m.bvalid), .in_ready_o(m.bready), .in_data_i(b_in),
        .out_valid_o(s.bvalid), .out_ready_i(s.bready), .out_data_o(b_out)
    );
    axi4_reg_slice_buf #(.W(R_W)) u_r (
        .clk_i(clk_i), .rst_n(rst_n),
        .in_valid_i(m.rvalid), .in_ready_o(m.rready), .in_data_i(r_in),
        .out_valid_o(s.rvalid), .out_ready_i(s.rready), .out_data_o(r_out)
    );
endmodule

// File: tb/tb_axi4_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_axi4_reg_slice : self-checking bench for axi4_reg_slice.
//
// The bench plays master on s and memory on m. Each of the five channels is
// viewed generically as (in_valid, in_ready, in_data) -> (out_valid, out_ready,
// out_data). A per-channel FIFO model holds every accepted beat; the expected
// output valid is "model not empty", the expected input ready is "room left"
// (two beats with AXI4_REG_SLICE_FULL_TPUT_EN, one without), and every output
// payload must equal the oldest beat in the model.
// -----------------------------------------------------------------------------
module tb_axi4_reg_slice;
`ifdef AXI4_REG_SLICE_FULL_TPUT_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam int DEPTH = 256;

    logic clk_i;
    logic rst_n;

    axi4_if #(.AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(2)) s_bus ();
    axi4_if #(.AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(2)) m_bus ();

    axi4_reg_slice #(
        .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(2)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .s(s_bus),
        .m(m_bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Generic channel view: 0=AW 1=W 2=AR 3=B 4=R
    logic [4:0]  in_valid;
    logic [4:0]  out_ready;
    logic [63:0] in_data [5];
    wire  [4:0]  in_ready;
    wire  [4:0]  out_valid;
    wire  [63:0] out_data [5];

    assign s_bus.awvalid = in_valid[0];
    assign in_ready[0]   = s_bus.awready;
    assign {s_bus.awaddr, s_bus.awid, s_bus.awlen, s_bus.awsize, s_bus.awburst, s_bus.awlock,
            s_bus.awcache, s_bus.awprot, s_bus.awqos, s_bus.awregion} = in_data[0][62:0];
    assign out_valid[0]  = m_bus.awvalid;
    assign m_bus.awready = out_ready[0];
    assign out_data[0]   = {1'b0, m_bus.awaddr, m_bus.awid, m_bus.awlen, m_bus.awsize, m_bus.awburst,
                            m_bus.awlock, m_bus.awcache, m_bus.awprot, m_bus.awqos, m_bus.awregion};

    assign s_bus.wvalid  = in_valid[1];
    assign in_ready[1]   = s_bus.wready;
    assign {s_bus.wdata, s_bus.wstrb, s_bus.wlast} = in_data[1][36:0];
    assign out_valid[1]  = m_bus.wvalid;
    assign m_bus.wready  = out_ready[1];
    assign out_data[1]   = {27'b0, m_bus.wdata, m_bus.wstrb, m_bus.wlast};

    assign s_bus.arvalid = in_valid[2];
    assign in_ready[2]   = s_bus.arready;
    assign {s_bus.araddr, s_bus.arid, s_bus.arlen, s_bus.arsize, s_bus.arburst, s_bus.arlock,
            s_bus.arcache, s_bus.arprot, s_bus.arqos, s_bus.arregion} = in_data[2][62:0];
    assign out_valid[2]  = m_bus.arvalid;
    assign m_bus.arready = out_ready[2];
    assign out_data[2]   = {1'b0, m_bus.araddr, m_bus.arid, m_bus.arlen, m_bus.arsize, m_bus.arburst,
                            m_bus.arlock, m_bus.arcache, m_bus.arprot, m_bus.arqos, m_bus.arregion};

    assign m_bus.bvalid  = in_valid[3];
    assign in_ready[3]   = m_bus.bready;
    assign {m_bus.bid, m_bus.bresp} = in_data[3][3:0];
    assign out_valid[3]  = s_bus.bvalid;
    assign s_bus.bready  = out_ready[3];
    assign out_data[3]   = {60'b0, s_bus.bid, s_bus.bresp};

    assign m_bus.rvalid  = in_valid[4];
    assign in_ready[4]   = m_bus.rready;
    assign {m_bus.rid, m_bus.rdata, m_bus.rresp, m_bus.rlast} = in_data[4][36:0];
    assign out_valid[4]  = s_bus.rvalid;
    assign s_bus.rready  = out_ready[4];
    assign out_data[4]   = {27'b0, s_bus.rid, s_bus.rdata, s_bus.rresp, s_bus.rlast};

    // Reference model: one FIFO of accepted beats per channel.
    logic [63:0] mq [5][DEPTH];
    int          head [5];
    int          tail [5];
    int          nin  [5];
    int          nout [5];
    logic [4:0]  fired_in;
    int          errors;
    int          checks;
    string       cn [5] = '{"AW", "W", "AR", "B", "R"};

    function automatic logic [63:0] chan_mask(input int c);
        int w;
        case (c)
            0, 2:    w = 63;
            3:       w = 4;
            default: w = 37;
        endcase
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of random traffic on all channels. Inputs change only
    // after a handshake, so held beats keep their payload (AXI4 rule).
    task automatic step(input int p_in, input int p_out);
        int occ;
        @(negedge clk_i);
        for (int c = 0; c < 5; c++) begin
            if (!in_valid[c] || fired_in[c]) begin
                in_valid[c] = ($urandom_range(0, 99) < p_in);
                in_data[c]  = {$urandom(), $urandom()} & chan_mask(c);
            end
            out_ready[c] = ($urandom_range(0, 99) < p_out);
        end
        #1;
        for (int c = 0; c < 5; c++) begin
            occ = tail[c] - head[c];
            chk($sformatf("%s_out_valid", cn[c]), {63'b0, out_valid[c]}, {63'b0, occ > 0});
            chk($sformatf("%s_in_ready", cn[c]), {63'b0, in_ready[c]}, {63'b0, occ < CAP});
            if (occ > 0)
                chk($sformatf("%s_payload", cn[c]), out_data[c], mq[c][head[c] % DEPTH]);
            fired_in[c] = in_valid[c] && in_ready[c];
            if (fired_in[c]) begin
                mq[c][tail[c] % DEPTH] = in_data[c];
                tail[c]++;
                nin[c]++;
            end
            if (out_valid[c] && out_ready[c] && occ > 0) begin
                head[c]++;
                nout[c]++;
            end
        end
    endtask

    initial begin
        int in0, out0;
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        in_valid = '0;
        out_ready = '0;
        fired_in = '0;
        for (int c = 0; c < 5; c++) begin
            in_data[c] = '0;
            head[c] = 0; tail[c] = 0; nin[c] = 0; nout[c] = 0;
        end

        // Reset state: outputs idle, inputs ready, payload cleared.
        repeat (3) @(negedge clk_i);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("%s_rst_valid", cn[c]), {63'b0, out_valid[c]}, 64'd0);
            chk($sformatf("%s_rst_ready", cn[c]), {63'b0, in_ready[c]}, 64'd1);
            chk($sformatf("%s_rst_payload", cn[c]), out_data[c], 64'd0);
        end
        rst_n = 1'b1;

        // Streaming: continuous valid and ready on every channel.
        in0  = nin[4];
        out0 = nout[4];
        repeat (16) step(100, 100);
        chk("R_stream_in", 64'(nin[4] - in0), (CAP == 2) ? 64'd16 : 64'd8);
        chk("R_stream_out", 64'(nout[4] - out0), (CAP == 2) ? 64'd15 : 64'd8);

        // Backpressure: downstream stalled, upstream pushing.
        repeat (6) step(0, 100);
        in0 = nin[0];
        repeat (4) step(100, 0);
        chk("AW_stall_accepted", 64'(nin[0] - in0), 64'(CAP));
        repeat (6) step(0, 100);
        chk("AW_stall_drained", 64'(nout[0]), 64'(nin[0]));

        // Random traffic under several load profiles.
        repeat (400) step(90, 90);
        repeat (400) step(90, 30);
        repeat (400) step(30, 90);
        repeat (400) step(60, 60);

        // Reset mid-operation: fill, then assert reset asynchronously.
        repeat (4) step(100, 0);
        @(negedge clk_i);
        in_valid  = '0;
        out_ready = '0;
        fired_in  = '0;
        rst_n     = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("%s_midrst_valid", cn[c]), {63'b0, out_valid[c]}, 64'd0);
            chk($sformatf("%s_midrst_ready", cn[c]), {63'b0, in_ready[c]}, 64'd1);
            chk($sformatf("%s_midrst_payload", cn[c]), out_data[c], 64'd0);
            head[c] = tail[c];
        end
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;

        // Traffic after reset must carry no stale beats.
        repeat (300) step(70, 70);
        repeat (8) step(0, 100);
        for (int c = 0; c < 5; c++)
            chk($sformatf("%s_final_empty", cn[c]), {63'b0, out_valid[c]}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
